multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Main control FSM for the multicycle RV32I core. It sequences the shared datapath (one memory port, one ALU, PC/IR/OldPC/Data/ALUOut registers) through fetch, decode, execute, memory and writeback. It generates every datapath select and write enable, and derives ALUControl by feeding its ALUOp into the ALU decoder instance it contains. Instruction fetch and data access share one memory port that answers with a ready handshake.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- op  in  7  instr[6:0] from IR
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory port completed access this cycle
- PCWrite  out  1  PC load enable
- AdrSrc  out  1  memory address: 0=PC, 1=ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR and OldPC load enable
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=RD1
- ALUSrcB  out  2  00=RD2, 01=ImmExt, 10=constant 4
- ImmSrc  out  2  00=I, 01=S, 10=B, 11=J
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- Illegal  out  1  unsupported instruction seen in DECODE
- State  out  4  current state encoding, for debug

## Operation
- State register: 4 bits, asynchronous reset to FETCH. All outputs are decoded combinationally from State, op, funct3, funct7b5, Zero and MemReady. No output is registered.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10. Codes 11-15 go to FETCH on the next edge with all enables 0.
- Supported opcodes:
  - lw = 0000011
  - sw = 0100011
  - R-type = 0110011
  - I-ALU = 0010011
  - beq = 1100011
  - jal = 1101111
- Defaults unless listed per state: all enables 0; ResultSrc, ALUSrcA, ALUSrcB = 00; ALUOp = 00; AdrSrc = 0.
- FETCH:
  - AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite = PCWrite = MemReady.
  - Stay in FETCH while MemReady=0; go to DECODE when MemReady=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next state:
  - lw or sw: MEMADR
  - R-type: EXECR
  - I-ALU: EXECI
  - jal: JAL
  - beq: BEQ
  - anything else: FETCH, with Illegal=1 for this cycle
  - R-type or I-ALU with funct3 not in {000,010,110,111}: also illegal, to FETCH
  - R-type with funct7b5=1 and funct3≠000: also illegal
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next state is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: AdrSrc=1, ResultSrc=00. Hold until MemReady, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held every cycle until MemReady=1, then FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10, then ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10, then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1, then ALUWB (rd = PC+4).
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=Zero, then FETCH.
- ImmSrc is decoded from op in every state:
  - lw, I-ALU: 00
  - sw: 01
  - beq: 10
  - jal: 11
  - others: 00
- ALU decode from ALUOp:
  - ALUOp=00: add
  - ALUOp=01: sub
  - ALUOp=10, funct3 decoded as:
    - 000: sub when op[5]&funct7b5, else add
    - 010: slt
    - 110: or
    - 111: and
  - ALUControl is never X in legal states; undefined cases return 000.

## Timing
- While reset=1: State=FETCH, and PCWrite, IRWrite, RegWrite, MemWrite and Illegal are forced to 0. The select outputs show FETCH values. ALUControl=000, State=0.
- Reset asserted mid-instruction aborts it immediately; no write enable can reach the datapath after reset rises.
- Cycles per instruction with MemReady tied high:
  - lw 5
  - sw 4
  - R/I 4
  - jal 4
  - beq 3
  - illegal 2
- Each cycle MemReady is low in FETCH, MEMREAD or MEMWRITE adds one cycle.
- MemReady is ignored in every other state.
- MemWrite never asserts outside MEMWRITE. At most one of RegWrite and MemWrite is high in any cycle.

## Test plan
- Reset asserted mid-EXECR: State goes to 0 asynchronously, RegWrite=0 in the same cycle. After release, FETCH with MemReady=1 gives IRWrite=PCWrite=1, ALUSrcB=10, ResultSrc=10.
- lw (op=0000011) with MemReady low for 2 cycles in FETCH and 1 cycle in MEMREAD: State sequence 0,0,0,1,2,3,3,4,0. RegWrite=1 only in MEMWB, with ResultSrc=01.
- sw then R-type sub (funct3=000, funct7b5=1):
  - sw: MemWrite high only in MEMWRITE, AdrSrc=1.
  - sub: ALUControl=001 in EXECR, RegWrite in ALUWB, 4 cycles total.
- beq with Zero=1, then beq with Zero=0: PCWrite=1 in BEQ only for the first. ALUControl=001 and ImmSrc=10 in both.
- jal (op=1101111): sequence 0,1,9,7,0. PCWrite=1 in JAL, ImmSrc=11, RegWrite=1 in ALUWB.
- op=1111111, and I-ALU with funct3=001: Illegal=1 for one cycle in DECODE, next state FETCH, no RegWrite/MemWrite/PCWrite during the instruction apart from its fetch.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main control FSM and ALU decoder for the multicycle RV32I core

// ALU decoder: maps the FSM's ALUOp plus funct fields to an ALUControl code
module multicycle_ctrl_aludec (
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       op5_i,
  input  logic       funct7b5_i,
  output logic [2:0] alu_control_o
);

  // Undefined ALUOp/funct3 combinations fall back to add so the output is never X
  always_comb begin
    alu_control_o = 3'b000;
    case (alu_op_i)
      2'b00: alu_control_o = 3'b000;
      2'b01: alu_control_o = 3'b001;
      2'b10: begin
        case (funct3_i)
          3'b000:  alu_control_o = (op5_i & funct7b5_i) ? 3'b001 : 3'b000;
          3'b010:  alu_control_o = 3'b101;
          3'b110:  alu_control_o = 3'b011;
          3'b111:  alu_control_o = 3'b010;
          default: alu_control_o = 3'b000;
        endcase
      end
      default: alu_control_o = 3'b000;
    endcase
  end

endmodule

// Control FSM sequencing the shared datapath through fetch/decode/execute/memory/writeback
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       Illegal,
  output logic [3:0] State
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_e;

  state_e     state_q, state_d;
  logic       pc_write, mem_write, ir_write, reg_write, illegal;
  logic [1:0] alu_op;
  logic       f3_ok, r_ok;

  // Only add/slt/or/and are implemented; sub is the sole funct7b5 variant allowed
  assign f3_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                 (funct3 == 3'b110) || (funct3 == 3'b111);
  assign r_ok  = f3_ok && !(funct7b5 && (funct3 != 3'b000));

  // State register, asynchronously returned to FETCH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state and raw per-state control decode
  always_comb begin
    state_d   = S_FETCH;
    pc_write  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    illegal   = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = 2'b00;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        ir_write  = MemReady;
        pc_write  = MemReady;
        state_d   = MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R: begin
            if (r_ok) state_d = S_EXECR;
            else      illegal = 1'b1;
          end
          OP_I: begin
            if (f3_ok) state_d = S_EXECI;
            else       illegal = 1'b1;
          end
          OP_JAL:  state_d = S_JAL;
          OP_BEQ:  state_d = S_BEQ;
          default: illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = MemReady ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
        state_d   = MemReady ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: reg_write = 1'b1;
      S_JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pc_write = 1'b1;
        state_d  = S_ALUWB;
      end
      S_BEQ: begin
        ALUSrcA  = 2'b10;
        alu_op   = 2'b01;
        pc_write = Zero;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Immediate format follows the opcode regardless of state
  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  multicycle_ctrl_aludec u_aludec (
    .alu_op_i      (alu_op),
    .funct3_i      (funct3),
    .op5_i         (op[5]),
    .funct7b5_i    (funct7b5),
    .alu_control_o (ALUControl)
  );

  // Enables are gated by reset so nothing reaches the datapath while it is asserted
  assign PCWrite  = pc_write  & ~reset;
  assign MemWrite = mem_write & ~reset;
  assign IRWrite  = ir_write  & ~reset;
  assign RegWrite = reg_write & ~reset;
  assign Illegal  = illegal   & ~reset;
  assign State    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, Zero, MemReady;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;
  logic [20:0] dut_vec;

  int checks = 0;
  int failures = 0;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .Illegal(Illegal), .State(State)
  );

  always #5 clk = ~clk;

  assign dut_vec = {State, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                    ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Illegal};

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IA = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Instruction legality from the supported-opcode and funct rules
  function automatic bit is_illegal(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    bit f3ok;
    f3ok = (f3 == 3'd0) || (f3 == 3'd2) || (f3 == 3'd6) || (f3 == 3'd7);
    if (o == LW || o == SW || o == JL || o == BQ) return 1'b0;
    if (o == IA) return !f3ok;
    if (o == RT) return !f3ok || (f7 && f3 != 3'd0);
    return 1'b1;
  endfunction

  // Expected output bundle for a given phase (state code) of an instruction
  function automatic logic [20:0] model_out(input int ph, input logic mr, input logic zr,
                                            input logic [6:0] o, input logic [2:0] f3,
                                            input logic f7, input bit ill);
    logic pcw, adr, mw, irw, rw, il;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] alu;
    pcw = (ph == 0 && mr) || ph == 9 || (ph == 10 && zr);
    adr = (ph == 3 || ph == 5);
    mw  = (ph == 5);
    irw = (ph == 0 && mr);
    rw  = (ph == 4 || ph == 7);
    rs  = (ph == 0) ? 2'd2 : (ph == 4) ? 2'd1 : 2'd0;
    sa  = (ph == 1 || ph == 9) ? 2'd1 :
          (ph == 2 || ph == 6 || ph == 8 || ph == 10) ? 2'd2 : 2'd0;
    sb  = (ph == 0 || ph == 9) ? 2'd2 : (ph == 1 || ph == 2 || ph == 8) ? 2'd1 : 2'd0;
    imm = (o == SW) ? 2'd1 : (o == BQ) ? 2'd2 : (o == JL) ? 2'd3 : 2'd0;
    alu = 3'd0;
    if (ph == 10) alu = 3'd1;
    else if (ph == 6 || ph == 8) begin
      case (f3)
        3'd0: alu = (o[5] && f7) ? 3'd1 : 3'd0;
        3'd2: alu = 3'd5;
        3'd6: alu = 3'd3;
        3'd7: alu = 3'd2;
        default: alu = 3'd0;
      endcase
    end
    il = (ph == 1) && ill;
    return {4'(ph), pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, il};
  endfunction

  // Hand-written sequence: nibble c of sts is the state expected in cycle c, bit c of mrs is MemReady
  task automatic run_seq(input string name, input int n, input logic [63:0] sts,
                         input logic [15:0] mrs, input logic ill);
    logic [3:0] st;
    for (int c = 0; c < n; c++) begin
      MemReady = mrs[c];
      st = sts[4*c +: 4];
      @(negedge clk);
      chk({name, ".state"}, State, st);
      chk({name, ".regwrite"}, RegWrite, (st == 4 || st == 7));
      chk({name, ".memwrite"}, MemWrite, (st == 5));
      chk({name, ".adrsrc"}, AdrSrc, (st == 3 || st == 5));
      chk({name, ".pcwrite"}, PCWrite, ((st == 0 && mrs[c]) || st == 9 || (st == 10 && Zero)));
      chk({name, ".irwrite"}, IRWrite, (st == 0 && mrs[c]));
      chk({name, ".illegal"}, Illegal, (st == 1 && ill));
      if (st == 4) chk({name, ".resultsrc"}, ResultSrc, 2'b01);
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic f7; logic zero;
    int cpi; logic [3:0] st2; logic [2:0] alu2; logic ill1; logic [1:0] imm;
  } vec_t;

  vec_t tbl[15];
  int   seq[$];

  initial begin
    #400000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1);
  end

  initial begin
    int cyc, idx, guard, kind;
    bit ill;

    tbl[0]  = '{LW, 3'd2, 1'b0, 1'b0, 5, 4'd2,  3'd0, 1'b0, 2'd0};
    tbl[1]  = '{SW, 3'd2, 1'b0, 1'b0, 4, 4'd2,  3'd0, 1'b0, 2'd1};
    tbl[2]  = '{RT, 3'd0, 1'b0, 1'b0, 4, 4'd6,  3'd0, 1'b0, 2'd0};
    tbl[3]  = '{RT, 3'd0, 1'b1, 1'b0, 4, 4'd6,  3'd1, 1'b0, 2'd0};
    tbl[4]  = '{RT, 3'd2, 1'b0, 1'b0, 4, 4'd6,  3'd5, 1'b0, 2'd0};
    tbl[5]  = '{RT, 3'd6, 1'b0, 1'b0, 4, 4'd6,  3'd3, 1'b0, 2'd0};
    tbl[6]  = '{RT, 3'd7, 1'b0, 1'b0, 4, 4'd6,  3'd2, 1'b0, 2'd0};
    tbl[7]  = '{IA, 3'd0, 1'b1, 1'b0, 4, 4'd8,  3'd0, 1'b0, 2'd0};
    tbl[8]  = '{IA, 3'd2, 1'b0, 1'b0, 4, 4'd8,  3'd5, 1'b0, 2'd0};
    tbl[9]  = '{JL, 3'd0, 1'b0, 1'b0, 4, 4'd9,  3'd0, 1'b0, 2'd3};
    tbl[10] = '{BQ, 3'd0, 1'b0, 1'b1, 3, 4'd10, 3'd1, 1'b0, 2'd2};
    tbl[11] = '{BQ, 3'd0, 1'b0, 1'b0, 3, 4'd10, 3'd1, 1'b0, 2'd2};
    tbl[12] = '{7'h7f, 3'd0, 1'b0, 1'b0, 2, 4'd0, 3'd0, 1'b1, 2'd0};
    tbl[13] = '{IA, 3'd1, 1'b0, 1'b0, 2, 4'd0,  3'd0, 1'b1, 2'd0};
    tbl[14] = '{RT, 3'd2, 1'b1, 1'b0, 2, 4'd0,  3'd0, 1'b1, 2'd0};

    // Reset state
    reset = 1'b1; op = LW; funct3 = 3'd2; funct7b5 = 1'b0; Zero = 1'b0; MemReady = 1'b1;
    #2;
    chk("rst.state", State, 4'd0);
    chk("rst.irwrite", IRWrite, 1'b0);
    chk("rst.pcwrite", PCWrite, 1'b0);
    chk("rst.alusrcb", ALUSrcB, 2'b10);
    chk("rst.resultsrc", ResultSrc, 2'b10);
    chk("rst.alucontrol", ALUControl, 3'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset mid-EXECR aborts immediately
    op = RT; funct3 = 3'd0; funct7b5 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midexec.before", State, 4'd6);
    #1 reset = 1'b1;
    #1;
    chk("midexec.state", State, 4'd0);
    chk("midexec.regwrite", RegWrite, 1'b0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midwb.before", RegWrite, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("midwb.regwrite", RegWrite, 1'b0);
    chk("midwb.state", State, 4'd0);
    @(negedge clk);
    chk("rsthold.irwrite", IRWrite, 1'b0);
    chk("rsthold.pcwrite", PCWrite, 1'b0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("release.irwrite", IRWrite, 1'b1);
    chk("release.pcwrite", PCWrite, 1'b1);
    chk("release.alusrcb", ALUSrcB, 2'b10);
    chk("release.resultsrc", ResultSrc, 2'b10);
    MemReady = 1'b0;
    @(posedge clk); #1;
    chk("release.stay", State, 4'd0);

    // Multi-cycle corner sequences
    op = LW; funct3 = 3'd2; funct7b5 = 1'b0;
    run_seq("lw", 9, 64'h043321000, 16'h00DC, 1'b0);
    op = SW;
    run_seq("sw", 6, 64'h055210, 16'h0017, 1'b0);
    op = RT; funct3 = 3'd0; funct7b5 = 1'b1;
    run_seq("sub", 5, 64'h07610, 16'h000F, 1'b0);
    op = BQ; Zero = 1'b1;
    run_seq("beqz1", 4, 64'h0A10, 16'h0007, 1'b0);
    Zero = 1'b0;
    run_seq("beqz0", 4, 64'h0A10, 16'h0007, 1'b0);
    op = JL;
    run_seq("jal", 5, 64'h07910, 16'h000F, 1'b0);
    op = 7'h7f;
    run_seq("illop", 3, 64'h010, 16'h0003, 1'b1);
    op = IA; funct3 = 3'd1; funct7b5 = 1'b0;
    run_seq("illf3", 3, 64'h010, 16'h0003, 1'b1);

    // Table-driven instruction vectors with MemReady held high
    for (int i = 0; i < 15; i++) begin
      op = tbl[i].op; funct3 = tbl[i].f3; funct7b5 = tbl[i].f7; Zero = tbl[i].zero;
      MemReady = 1'b1;
      cyc = 0;
      while (1) begin
        @(negedge clk);
        if (cyc == 1) begin
          chk($sformatf("tbl%0d.illegal", i), Illegal, tbl[i].ill1);
          chk($sformatf("tbl%0d.immsrc", i), ImmSrc, tbl[i].imm);
        end
        if (cyc == 2) begin
          chk($sformatf("tbl%0d.state2", i), State, tbl[i].st2);
          chk($sformatf("tbl%0d.alu2", i), ALUControl, tbl[i].alu2);
        end
        @(posedge clk); #1;
        cyc++;
        if (State == 4'd0 || cyc > 20) break;
      end
      chk($sformatf("tbl%0d.cpi", i), cyc, tbl[i].cpi);
    end

    // Random instruction stream against the phase-sequence model
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 7);
      case (kind)
        0: op = LW; 1: op = SW; 2: op = RT; 3: op = IA;
        4: op = JL; 5: op = BQ; 6: op = 7'($urandom_range(0, 127));
        default: op = RT;
      endcase
      funct3 = 3'($urandom_range(0, 7));
      funct7b5 = 1'($urandom_range(0, 1));
      ill = is_illegal(op, funct3, funct7b5);
      if (ill)             seq = '{0, 1};
      else if (op == LW)   seq = '{0, 1, 2, 3, 4};
      else if (op == SW)   seq = '{0, 1, 2, 5};
      else if (op == RT)   seq = '{0, 1, 6, 7};
      else if (op == IA)   seq = '{0, 1, 8, 7};
      else if (op == JL)   seq = '{0, 1, 9, 7};
      else                 seq = '{0, 1, 10};
      idx = 0;
      guard = 0;
      while (idx < seq.size()) begin
        MemReady = ($urandom_range(0, 3) != 0);
        Zero = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk($sformatf("rand%0d.ph%0d", n, seq[idx]), dut_vec,
            model_out(seq[idx], MemReady, Zero, op, funct3, funct7b5, ill));
        @(posedge clk); #1;
        if (!((seq[idx] == 0 || seq[idx] == 3 || seq[idx] == 5) && !MemReady)) idx++;
        guard++;
        if (guard > 200) begin
          chk("rand.timeout", guard, 200);
          break;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
